// File: rtl/result_serializer_pkg.sv
// Shared definitions for the result serializer: frame sync byte, byte-count
// helper and the serializer FSM state encoding.
package result_serializer_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam int         DATA_W_DEF = 40;

  function automatic int num_bytes(input int data_w);
    return data_w / 8;
  endfunction

  localparam int NB = num_bytes(DATA_W_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } ser_state_e;

endpackage

// File: rtl/result_serializer_if.sv
// Result-word write port and byte-stream port of the result serializer.
// The slave modport is the serializer's view; master is the harness/host view.
interface result_serializer_if #(
  parameter int DATA_W = result_serializer_pkg::DATA_W_DEF
);

  logic              fifo_wr_en;
  logic [DATA_W-1:0] dut_dout;
  logic              fifo_full;
  logic [7:0]        byte_dout;
  logic              byte_valid;
  logic              byte_ready;

  modport master (
    output fifo_wr_en, dut_dout, byte_ready,
    input  fifo_full, byte_dout, byte_valid
  );

  modport slave (
    input  fifo_wr_en, dut_dout, byte_ready,
    output fifo_full, byte_dout, byte_valid
  );

endinterface

// File: rtl/result_fifo.sv
// Single-clock synchronous FIFO with inferred block RAM. dout is the registered
// head word, so after a pop the next head is valid one cycle later.
module result_fifo #(
  parameter int DATA_W = 40,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W:0]   count
);

  localparam int                DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_C    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ZERO_C = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE_C  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE_C  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic [DATA_W-1:0] dout_r;
  logic              wr_ok_s;
  logic              rd_ok_s;

  assign wr_ok_s = wr_en && (count_r != DEPTH_C);
  assign rd_ok_s = rd_en && (count_r != CNT_ZERO_C);

  // RAM write port; storage is left unreset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // registered head-word read
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r <= {DATA_W{1'b0}};
    end else begin
      dout_r <= mem_r[rd_ptr_r];
    end
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      count_r  <= CNT_ZERO_C;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE_C;
        2'b01:   count_r <= count_r - CNT_ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = dout_r;
  assign count = count_r;

endmodule

// File: rtl/result_serializer.sv
// Buffers DUT result words and streams them MSB-first as bytes to the host link.
// Optional macro RESULT_SERIALIZER_SYNC_EN prefixes every word with SYNC_BYTE.
module result_serializer
  import result_serializer_pkg::*;
#(
  parameter int DATA_W = 40,
  parameter int ADDR_W = 6,
  parameter int SLACK  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  result_serializer_if.slave   bus,
  output logic [15:0]          word_count,
  output logic                 overflow
);

  localparam int NB_L = num_bytes(DATA_W);
`ifdef RESULT_SERIALIZER_SYNC_EN
  localparam int FRAME_B = NB_L + 1;
`else
  localparam int FRAME_B = NB_L;
`endif
  localparam logic [ADDR_W:0] DEPTH_C    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] FULL_THR_C = (ADDR_W+1)'((1 << ADDR_W) - SLACK);
  localparam logic [ADDR_W:0] CNT_ZERO_C = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] CNT_ONE_C  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [3:0]      LAST_IDX_C = 4'(FRAME_B - 1);

  ser_state_e        state_r;
  logic [DATA_W-1:0] shift_r;
  logic [7:0]        byte_dout_r;
  logic              byte_valid_r;
  logic [3:0]        idx_r;
  logic [15:0]       word_count_r;
  logic              fifo_full_r;
  logic              overflow_r;

  logic [DATA_W-1:0] fifo_dout_s;
  logic [ADDR_W:0]   count_s;
  logic [ADDR_W:0]   count_next_s;
  logic              wr_accept_s;
  logic              pop_s;

  assign wr_accept_s = bus.fifo_wr_en && (count_s != DEPTH_C);
  assign pop_s       = (state_r == ST_LOAD);

  result_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_accept_s),
    .din   (bus.dut_dout),
    .rd_en (pop_s),
    .dout  (fifo_dout_s),
    .count (count_s)
  );

  // occupancy after this edge, used for the registered back-pressure flag
  always_comb begin
    count_next_s = count_s;
    case ({wr_accept_s, pop_s})
      2'b10:   count_next_s = count_s + CNT_ONE_C;
      2'b01:   count_next_s = count_s - CNT_ONE_C;
      default: count_next_s = count_s;
    endcase
  end

  // back-pressure and sticky overflow flags
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_full_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      fifo_full_r <= (count_next_s >= FULL_THR_C);
      if (bus.fifo_wr_en && (count_s == DEPTH_C)) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // serializer FSM: LOAD captures the registered FIFO head, SEND shifts bytes out
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      shift_r      <= {DATA_W{1'b0}};
      byte_dout_r  <= 8'h00;
      byte_valid_r <= 1'b0;
      idx_r        <= 4'd0;
      word_count_r <= 16'h0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          byte_valid_r <= 1'b0;
          if (count_s != CNT_ZERO_C) begin
            state_r <= ST_LOAD;
          end
        end
        ST_LOAD: begin
`ifdef RESULT_SERIALIZER_SYNC_EN
          byte_dout_r <= SYNC_BYTE;
          shift_r     <= fifo_dout_s;
`else
          byte_dout_r <= fifo_dout_s[DATA_W-1 -: 8];
          shift_r     <= {fifo_dout_s[DATA_W-9:0], 8'h00};
`endif
          idx_r        <= 4'd0;
          byte_valid_r <= 1'b1;
          state_r      <= ST_SEND;
        end
        ST_SEND: begin
          if (byte_valid_r && bus.byte_ready) begin
            if (idx_r == LAST_IDX_C) begin
              byte_valid_r <= 1'b0;
              if (word_count_r != 16'hFFFF) begin
                word_count_r <= word_count_r + 16'd1;
              end
              state_r <= (count_s != CNT_ZERO_C) ? ST_LOAD : ST_IDLE;
            end else begin
              byte_dout_r <= shift_r[DATA_W-1 -: 8];
              shift_r     <= {shift_r[DATA_W-9:0], 8'h00};
              idx_r       <= idx_r + 4'd1;
            end
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          byte_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fifo_full  = fifo_full_r;
  assign bus.byte_dout  = byte_dout_r;
  assign bus.byte_valid = byte_valid_r;
  assign word_count     = word_count_r;
  assign overflow       = overflow_r;

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench for result_serializer: expected bytes are queued on each
// accepted write and compared when the link accepts a byte.
module tb_result_serializer;
  import result_serializer_pkg::*;

  localparam int DATA_W = 40;
`ifdef RESULT_SERIALIZER_SYNC_EN
  localparam int FRAME_B = 6;
`else
  localparam int FRAME_B = 5;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] word_count;
  logic        overflow;

  int          total_cnt = 0;
  int          bad_cnt   = 0;
  logic [7:0]  exp_q [$];
  logic        hold_pending = 1'b0;
  logic [7:0]  held_byte    = 8'h00;

  result_serializer_if #(.DATA_W(DATA_W)) bus ();

  result_serializer #(
    .DATA_W (DATA_W),
    .ADDR_W (6),
    .SLACK  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .word_count (word_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // byte scoreboard and hold-stability monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (hold_pending) begin
      check_eq("hold_valid", 40'(bus.byte_valid), 40'h1);
      check_eq("hold_byte", 40'(bus.byte_dout), 40'(held_byte));
    end
    if (!rst && bus.byte_valid && bus.byte_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_byte", 40'(bus.byte_dout), 40'h100);
      end else begin
        check_eq("byte", 40'(bus.byte_dout), 40'(exp_q.pop_front()));
      end
    end
    hold_pending <= !rst && bus.byte_valid && !bus.byte_ready;
    held_byte    <= bus.byte_dout;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_word(input logic [39:0] w);
`ifdef RESULT_SERIALIZER_SYNC_EN
    exp_q.push_back(8'hA5);
`endif
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(w[39-8*k -: 8]);
    end
  endtask

  task automatic wr(input logic [39:0] w, input bit accepted);
    bus.fifo_wr_en = 1'b1;
    bus.dut_dout   = w;
    if (accepted) push_word(w);
    tick();
    bus.fifo_wr_en = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!bus.byte_valid && n < budget) begin
      tick();
      n++;
    end
    check_eq("wait_valid", 40'(bus.byte_valid), 40'h1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check_eq("drain_left", 40'(exp_q.size()), 40'h0);
    repeat (3) tick();
  endtask

  // write into an idle FIFO with ready high and check the 3-cycle latency
  task automatic latency_word(input logic [39:0] w, input logic [15:0] wc_exp);
    wr(w, 1'b1);
    @(negedge clk); check_eq("lat_idle", 40'(bus.byte_valid), 40'h0);
    @(negedge clk); check_eq("lat_load", 40'(bus.byte_valid), 40'h0);
    @(negedge clk); check_eq("lat_first", 40'(bus.byte_valid), 40'h1);
    for (int k = 1; k < FRAME_B; k++) begin
      @(negedge clk); check_eq("lat_stream", 40'(bus.byte_valid), 40'h1);
    end
    @(negedge clk);
    check_eq("lat_end", 40'(bus.byte_valid), 40'h0);
    check_eq("lat_wc", 40'(word_count), 40'(wc_exp));
    check_eq("lat_full", 40'(bus.fifo_full), 40'h0);
  endtask

  function automatic logic [39:0] mk_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, 8'h5A ^ b, b + 8'h11, 8'hC3};
  endfunction

  initial begin
    rst            = 1'b1;
    bus.fifo_wr_en = 1'b0;
    bus.dut_dout   = 40'h0;
    bus.byte_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_full", 40'(bus.fifo_full), 40'h0);
    check_eq("rst_valid", 40'(bus.byte_valid), 40'h0);
    check_eq("rst_dout", 40'(bus.byte_dout), 40'h0);
    check_eq("rst_wc", 40'(word_count), 40'h0);
    check_eq("rst_ovf", 40'(overflow), 40'h0);

    // single word, ready held high
    bus.byte_ready = 1'b1;
    latency_word(40'h0123456789, 16'd1);

    // back-pressure with ready pattern 1,0,0
    wr(40'hFFEEDDCCBB, 1'b1);
    for (int i = 0; i < 36; i++) begin
      bus.byte_ready = (i % 3 == 0);
      tick();
    end
    check_eq("bp_left", 40'(exp_q.size()), 40'h0);
    check_eq("bp_wc", 40'(word_count), 40'd2);

    // fill and overflow with one word already held in SEND
    bus.byte_ready = 1'b0;
    wr(40'h1122334455, 1'b1);
    wait_valid(10);
    for (int i = 0; i < 66; i++) begin
      wr(mk_word(i), i < 64);
      if (i == 58) check_eq("full_at59", 40'(bus.fifo_full), 40'h0);
      if (i == 59) begin
        check_eq("full_at60", 40'(bus.fifo_full), 40'h1);
        check_eq("ovf_at60", 40'(overflow), 40'h0);
      end
      if (i == 63) check_eq("ovf_at64", 40'(overflow), 40'h0);
      if (i == 64) check_eq("ovf_drop", 40'(overflow), 40'h1);
    end
    bus.byte_ready = 1'b1;
    drain(65 * (FRAME_B + 1) + 50);
    check_eq("ovf_wc", 40'(word_count), 40'd67);
    check_eq("ovf_full_after", 40'(bus.fifo_full), 40'h0);
    check_eq("ovf_sticky", 40'(overflow), 40'h1);

    // simultaneous write and LOAD pop at count 59
    bus.byte_ready = 1'b0;
    wr(40'hA0B0C0D0E0, 1'b1);
    wait_valid(10);
    for (int i = 0; i < 59; i++) wr(mk_word(100 + i), 1'b1);
    check_eq("rw_full59", 40'(bus.fifo_full), 40'h0);
    bus.byte_ready = 1'b1;
    repeat (FRAME_B) tick();
    check_eq("rw_load_gap", 40'(bus.byte_valid), 40'h0);
    bus.byte_ready = 1'b0;
    wr(mk_word(200), 1'b1);
    check_eq("rw_full_stay", 40'(bus.fifo_full), 40'h0);
    wr(mk_word(201), 1'b1);
    check_eq("rw_full_at60", 40'(bus.fifo_full), 40'h1);
    bus.byte_ready = 1'b1;
    for (int n = 0; n < 20 && bus.fifo_full; n++) tick();
    check_eq("rw_full_release", 40'(bus.fifo_full), 40'h0);
    drain(62 * (FRAME_B + 1) + 50);
    check_eq("rw_wc", 40'(word_count), 40'd129);

    // reset mid-frame with three words queued
    bus.byte_ready = 1'b0;
    wr(40'h1010101010, 1'b1);
    wr(40'h2020202020, 1'b1);
    wr(40'h3030303030, 1'b1);
    wait_valid(10);
    check_eq("ovf_before_rst", 40'(overflow), 40'h1);
    bus.byte_ready = 1'b1;
    tick();
    tick();
    rst            = 1'b1;
    bus.byte_ready = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_valid", 40'(bus.byte_valid), 40'h0);
    check_eq("mid_rst_wc", 40'(word_count), 40'h0);
    check_eq("mid_rst_full", 40'(bus.fifo_full), 40'h0);
    check_eq("mid_rst_ovf", 40'(overflow), 40'h0);
    check_eq("mid_rst_dout", 40'(bus.byte_dout), 40'h0);
    bus.byte_ready = 1'b1;
    latency_word(40'h0F1E2D3C4B, 16'd1);
    repeat (4) tick();
    check_eq("final_left", 40'(exp_q.size()), 40'h0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/result_serializer.md
Name: result_serializer

Overview:
- Downstream stage of the DUT test harness.
- Accepts 40-bit DUT result words plus a write strobe, buffers them in an internal synchronous FIFO, and emits them as a byte stream for the UART/host link.
- Generates the `fifo_full` back-pressure that the harness samples to stall the DUT.
- Single clock domain: the same clock as the harness.

Parameters:
- DATA_W, 40, width of input result word; must be a multiple of 8.
- ADDR_W, 6, FIFO address bits; depth = 2**ADDR_W words (64).
- SLACK, 4, number of free entries still remaining when `fifo_full` asserts; absorbs the harness's registered-full latency.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- fifo_wr_en  in  1  write strobe for one result word.
- dut_dout  in  DATA_W  result word; valid when fifo_wr_en=1.
- fifo_full  out  1  back-pressure to the harness.
- byte_dout  out  8  serialized output byte.
- byte_valid  out  1  byte_dout holds a valid byte.
- byte_ready  in  1  consumer accepts the byte this cycle.
- word_count  out  16  words fully transmitted, saturating.
- overflow  out  1  sticky: a write arrived while the FIFO was truly full.

Behaviour:
- Reset (rst=1 sampled on a clk edge):
  - Pointers and count are cleared.
  - fifo_full=0, byte_valid=0, byte_dout=0, word_count=0, overflow=0.
  - FSM goes to IDLE.
  - Reset mid-frame discards the partial word and all buffered data.
- FIFO:
  - Write occurs when fifo_wr_en=1 and count<DEPTH; count is incremented.
  - A write when count==DEPTH is dropped and sets overflow=1. Overflow clears only on rst.
  - Read pops the head word when the FSM is in LOAD.
  - Simultaneous read and write leaves count unchanged; both proceed.
- fifo_full:
  - Registered.
  - Value on the next edge is (count_next >= DEPTH-SLACK).
  - Deasserts when count_next < DEPTH-SLACK; no hysteresis.
- Byte order: MSB first; byte k = dut_dout[DATA_W-1-8k -: 8], k=0..NB-1, where NB=DATA_W/8 (5).
- FSM:
  - IDLE: if count>0, go to LOAD; else stay. byte_valid=0.
  - LOAD: pop head word into the shift register, set byte index=0, go to SEND. byte_valid=0 this cycle.
  - SEND:
    - byte_valid=1; byte_dout=shift[DATA_W-1 -: 8].
    - On byte_valid & byte_ready: shift left 8 bits and increment the index.
    - If the last byte is accepted: increment word_count (saturates at 0xFFFF). Then go to LOAD if count>0, else IDLE.
    - If byte_ready=0: hold byte_dout and byte_valid stable, with no change.
- Latency:
  - A write into an empty FIFO in cycle N gives count=1 at edge N+1.
  - LOAD occurs in cycle N+2.
  - The first byte_valid appears in cycle N+3.
  - Throughput is NB bytes per NB+1 cycles when byte_ready is held high.
- byte_dout changes only on acceptance or on entering SEND. It is never X while byte_valid=1.

Optional Feature:
- Macro: RESULT_SERIALIZER_SYNC_EN.
- Defined:
  - Each word is framed with a leading sync byte 0xA5 followed by the NB data bytes (NB+1 bytes per word).
  - SEND begins with the sync byte.
  - word_count increments after the last data byte.
- Undefined: no sync byte; NB bytes per word as above.

Decomposition:
- Shared package: SYNC_BYTE=8'hA5, the FSM state encoding (IDLE, LOAD, SEND), and NB as a derived constant.
- One sub-module, result_fifo: synchronous single-clock FIFO with inferred block RAM.
  - Parameters: DATA_W, ADDR_W.
  - Ports: clk, rst, wr_en, din, rd_en, dout, count.
  - Registered read: dout is valid one cycle after rd_en. The LOAD state accounts for this with one extra wait cycle, and the latency above includes it.
- Serializer FSM, full logic and counters live in the top.

Test Plan:
- Single word, byte_ready=1:
  - Stimulus: one write of 40'h0123456789.
  - Bytes 01,23,45,67,89 on 5 consecutive valid cycles.
  - word_count=1; fifo_full stays 0.
  - With the macro defined: A5 precedes 01.
- Back-pressure:
  - Stimulus: byte_ready toggles 1,0,0,1… during a word of 40'hFFEEDDCCBB.
  - Each byte is held stable while ready=0.
  - Output sequence FF,EE,DD,CC,BB with no duplicates or losses.
- Fill:
  - Stimulus: byte_ready=0 and 60 consecutive writes.
  - fifo_full asserts on the edge after the 60th write (count=60=64-4).
  - overflow=0.
  - Draining below 60 deasserts fifo_full.
- Overflow:
  - Stimulus: byte_ready=0 and 66 writes.
  - Writes 65–66 are dropped; overflow=1 and is sticky.
  - Drain outputs exactly 64 words, in order.
- Simultaneous read/write at count=59:
  - Stimulus: a write on the same cycle as a LOAD pop.
  - count stays 59 and fifo_full stays 0.
- Reset mid-frame:
  - Stimulus: rst=1 for one cycle after byte 2 of a word, with 3 words queued.
  - Next cycle: byte_valid=0, word_count=0, fifo_full=0, overflow=0.
  - A new write afterwards produces its first byte exactly 3 cycles later.
